// File: rtl/wide_dec_parser_if.sv
`default_nettype none
// ============================================================================
//  Module      : wide_dec_parser_if
//  Description : Byte-stream input and wide-result output bundle for the
//                ASCII-decimal to wide-binary parser.
//  Revision    : 1.0  initial release
// ============================================================================
interface wide_dec_parser_if #(
    parameter int WIDTH = 4096,
    parameter int NDW   = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_char;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic [NDW-1:0]   out_ndigits;
    logic             out_overflow;
    logic             out_error;

    // Byte source / result consumer side
    modport master (
        output in_valid, in_char, out_ready,
        input  in_ready, out_valid, out_value, out_ndigits, out_overflow, out_error
    );

    // Parser side
    modport slave (
        input  in_valid, in_char, out_ready,
        output in_ready, out_valid, out_value, out_ndigits, out_overflow, out_error
    );
endinterface
`default_nettype wire

// File: rtl/wide_dec_parser.sv
`default_nettype none
// ============================================================================
//  Module      : wide_dec_parser
//  Description : Streaming ASCII-decimal to WIDTH-bit unsigned binary
//                converter. One character per cycle, sticky overflow,
//                saturating digit count, illegal-character drain to newline.
//  Revision    : 1.0  initial release
// ============================================================================
module wide_dec_parser #(
    parameter int WIDTH = 4096,
    parameter int NDW   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    wide_dec_parser_if.slave   bus
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_digits = 2'd1;
    localparam logic [1:0] c_st_drain  = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [NDW-1:0]   ndig_q, ndig_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] out_value_q, out_value_d;
    logic [NDW-1:0]   out_ndigits_q, out_ndigits_d;
    logic             out_overflow_q, out_overflow_d;
    logic             out_error_q, out_error_d;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_is_digit;
    logic             w_is_nl;
    logic             w_is_ws;
    logic [WIDTH+3:0] w_acc_ext;
    logic [WIDTH+3:0] w_acc_next;
    logic [NDW-1:0]   w_ndig_inc;

    // Character classification and the x10+digit step (shift-add, no multiplier)
    always_comb begin
        w_is_digit = (bus.in_char >= 8'h30) && (bus.in_char <= 8'h39);
        w_is_nl    = (bus.in_char == 8'h0A);
        w_is_ws    = (bus.in_char == 8'h20) || (bus.in_char == 8'h09) ||
                     (bus.in_char == 8'h0D) || w_is_nl;
        w_accept   = bus.in_valid && w_in_ready;
        w_acc_ext  = {4'b0000, acc_q};
        w_acc_next = (w_acc_ext << 3) + (w_acc_ext << 1) +
                     {{WIDTH{1'b0}}, bus.in_char[3:0]};
        w_ndig_inc = (ndig_q == {NDW{1'b1}}) ? ndig_q : ndig_q + NDW'(1);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: begin
                if (w_accept) begin
                    if (w_is_digit)    state_d = c_st_digits;
                    else if (!w_is_ws) state_d = c_st_drain;
                end
            end
            c_st_digits: begin
                if (w_accept) begin
                    if (w_is_ws)          state_d = c_st_done;
                    else if (!w_is_digit) state_d = c_st_drain;
                end
            end
            c_st_drain: begin
                if (w_accept && w_is_nl) state_d = c_st_done;
            end
            c_st_done: begin
                if (bus.out_ready) state_d = c_st_idle;
            end
            default: state_d = c_st_idle;
        endcase
    end

    // Handshake outputs decoded purely from the state register
    always_comb begin
        w_in_ready  = (state_q != c_st_done);
        w_out_valid = (state_q == c_st_done);
    end

    // Accumulator, digit count and sticky overflow for the number in flight
    always_comb begin
        acc_d  = acc_q;
        ndig_d = ndig_q;
        ovf_d  = ovf_q;
        if (w_accept) begin
            case (state_q)
                c_st_idle: begin
                    if (w_is_digit) begin
                        acc_d  = {{(WIDTH-4){1'b0}}, bus.in_char[3:0]};
                        ndig_d = NDW'(1);
                        ovf_d  = 1'b0;
                    end else if (!w_is_ws) begin
                        // Error before any digit: count of digits seen is zero
                        ndig_d = '0;
                        ovf_d  = 1'b0;
                    end
                end
                c_st_digits: begin
                    if (w_is_digit) begin
                        acc_d  = w_acc_next[WIDTH-1:0];
                        ovf_d  = ovf_q | (|w_acc_next[WIDTH+3:WIDTH]);
                        ndig_d = w_ndig_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result registers load only on entry to DONE; DRAIN entry means error
    always_comb begin
        out_value_d    = out_value_q;
        out_ndigits_d  = out_ndigits_q;
        out_overflow_d = out_overflow_q;
        out_error_d    = out_error_q;
        if ((state_q != c_st_done) && (state_d == c_st_done)) begin
            out_ndigits_d = ndig_q;
            if (state_q == c_st_drain) begin
                out_value_d    = '0;
                out_overflow_d = 1'b0;
                out_error_d    = 1'b1;
            end else begin
                out_value_d    = acc_q;
                out_overflow_d = ovf_q;
                out_error_d    = 1'b0;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q          <= '0;
            ndig_q         <= '0;
            ovf_q          <= 1'b0;
            out_value_q    <= '0;
            out_ndigits_q  <= '0;
            out_overflow_q <= 1'b0;
            out_error_q    <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            ndig_q         <= ndig_d;
            ovf_q          <= ovf_d;
            out_value_q    <= out_value_d;
            out_ndigits_q  <= out_ndigits_d;
            out_overflow_q <= out_overflow_d;
            out_error_q    <= out_error_d;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_value    = out_value_q;
    assign bus.out_ndigits  = out_ndigits_q;
    assign bus.out_overflow = out_overflow_q;
    assign bus.out_error    = out_error_q;

endmodule
`default_nettype wire

// File: tb/tb_wide_dec_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wide_dec_parser
//  Description : Scoreboard bench driving one character stream into a
//                64-bit and a 4096-bit parser side by side.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wide_dec_parser;

    localparam int WS  = 64;
    localparam int WL  = 4096;
    localparam int NDW = 16;

    typedef struct {
        logic [4095:0] val;
        int            nd;
        logic          ovf;
        logic          err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_char;
    logic       out_ready;

    exp_t q64[$];
    exp_t q4k[$];
    byte  dec_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    wide_dec_parser_if #(.WIDTH(WS), .NDW(NDW)) bus64 ();
    wide_dec_parser_if #(.WIDTH(WL), .NDW(NDW)) bus4k ();

    assign bus64.in_valid  = in_valid;
    assign bus64.in_char   = in_char;
    assign bus64.out_ready = out_ready;
    assign bus4k.in_valid  = in_valid;
    assign bus4k.in_char   = in_char;
    assign bus4k.out_ready = out_ready;

    wide_dec_parser #(.WIDTH(WS), .NDW(NDW)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));
    wide_dec_parser #(.WIDTH(WL), .NDW(NDW)) dut4k (.clk(clk), .rst_n(rst_n), .bus(bus4k));

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [4095:0] got, input logic [4095:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (low 128 bits shown)", tag, got[127:0], exp[127:0]);
        end
    endtask

    // Push the expected result of one number into both scoreboards
    task automatic expect_pair(input logic [4095:0] v, input int nd, input logic err);
        exp_t e;
        e.nd  = nd;
        e.err = err;
        e.val = err ? '0 : {4032'b0, v[63:0]};
        e.ovf = err ? 1'b0 : (|v[4095:64]);
        q64.push_back(e);
        e.val = err ? '0 : v;
        e.ovf = 1'b0;
        q4k.push_back(e);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present one char and hold it until accepted (call at posedge+1)
    task automatic drive_char(input logic [7:0] c);
        logic ok;
        int   n;
        in_valid = 1'b1;
        in_char  = c;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = bus64.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) check_val("in_timeout", 0, 1);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) drive_char(s[i]);
    endtask

    task automatic send_dec();
        for (int i = 0; i < dec_q.size(); i++) drive_char(dec_q[i]);
        drive_char(8'h0A);
    endtask

    // Decimal text of a wide value, built by repeated division
    task automatic build_dec(input logic [4095:0] v_in);
        logic [4095:0] v;
        logic [4095:0] r;
        dec_q.delete();
        v = v_in;
        if (v == '0) dec_q.push_back(8'h30);
        while (v != '0) begin
            r = v % 10;
            dec_q.push_front(byte'(8'h30 + r[7:0]));
            v = v / 10;
        end
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while ((q64.size() != 0 || q4k.size() != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check_val("drain_pending", q64.size() + q4k.size(), 0);
        sync();
    endtask

    // 64-bit result monitor
    always @(negedge clk) begin : mon64
        exp_t e;
        if (rst_n && bus64.out_valid && out_ready) begin
            if (q64.size() == 0) begin
                check_val("s_unexpected", 1, 0);
            end else begin
                e = q64.pop_front();
                check_val("s_value", {4032'b0, bus64.out_value}, e.val);
                check_val("s_ndigits", {4080'b0, bus64.out_ndigits}, e.nd);
                check_val("s_overflow", bus64.out_overflow, e.ovf);
                check_val("s_error", bus64.out_error, e.err);
            end
        end
    end

    // 4096-bit result monitor
    always @(negedge clk) begin : mon4k
        exp_t e;
        if (rst_n && bus4k.out_valid && out_ready) begin
            if (q4k.size() == 0) begin
                check_val("l_unexpected", 1, 0);
            end else begin
                e = q4k.pop_front();
                check_val("l_value", bus4k.out_value, e.val);
                check_val("l_ndigits", {4080'b0, bus4k.out_ndigits}, e.nd);
                check_val("l_overflow", bus4k.out_overflow, e.ovf);
                check_val("l_error", bus4k.out_error, e.err);
            end
        end
    end

    initial begin
        logic [4095:0] v;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_out_valid", bus64.out_valid, 0);
        check_val("rst_out_value", bus4k.out_value, 0);
        check_val("rst_out_ndigits", bus64.out_ndigits, 0);
        check_val("rst_out_overflow", bus64.out_overflow, 0);
        check_val("rst_out_error", bus4k.out_error, 0);
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_in_ready", bus64.in_ready, 1);
        sync();

        // Basic: valid the cycle after the terminator, ready low in DONE
        expect_pair(4096'd42, 2, 1'b0);
        send_str("42\n");
        @(negedge clk);
        check_val("basic_out_valid", bus64.out_valid, 1);
        check_val("basic_in_ready_low", bus64.in_ready, 0);
        sync();

        // Whitespace and leading zeros
        expect_pair(4096'd7, 3, 1'b0);
        expect_pair(4096'd13, 2, 1'b0);
        send_str("  007 13\n");

        // 64-bit boundary
        expect_pair({4032'b0, 64'hFFFF_FFFF_FFFF_FFFF}, 20, 1'b0);
        send_str("18446744073709551615\n");
        v = '0;
        v[64] = 1'b1;
        expect_pair(v, 20, 1'b0);
        send_str("18446744073709551616\n");

        // Illegal character, drain to newline, then recover
        expect_pair('0, 2, 1'b1);
        expect_pair(4096'd5, 1, 1'b0);
        send_str("12a4 99\n5\n");
        wait_empty();

        // Backpressure: consumer stalls while the source keeps streaming
        out_ready = 1'b0;
        expect_pair(4096'd1, 1, 1'b0);
        expect_pair(4096'd2, 1, 1'b0);
        fork
            send_str("1\n2\n");
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check_val("bp_held_valid", bus64.out_valid, 1);
                check_val("bp_held_ready", bus64.in_ready, 0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_empty();

        // Reset mid-number discards the partial value
        send_str("123");
        rst_n = 1'b0;
        @(negedge clk);
        check_val("midrst_out_valid", bus64.out_valid, 0);
        check_val("midrst_out_value", bus64.out_value, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_pair(4096'd9, 1, 1'b0);
        send_str("9\n");
        wait_empty();

        // Wide round trip of a pseudo-random pattern
        for (int i = 0; i < 128; i++) v[i*32 +: 32] = $urandom;
        v[4095] = 1'b1;
        build_dec(v);
        expect_pair(v, dec_q.size(), 1'b0);
        send_dec();
        wait_empty();

        // All ones at 4096 bits: 1234 digits
        v = '1;
        build_dec(v);
        expect_pair(v, 1234, 1'b0);
        send_dec();
        wait_empty();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
